fan_speed_governor: RTL and testbench
=====================================

Name: fan_speed_governor

Overview:
- Temperature-driven speed selector placed directly upstream of the fan PWM/power driver.
- Consumes periodic temperature samples and applies hysteresis thresholds, a minimum dwell time between speed steps, and a full-speed spin-up kick when the fan starts.
- Drives the driver's fan_switch and its 2-bit speed choice. speed_choice feeds both pwm_choice and power_choice.
- Speed encoding matches the driver: 00 = 25%, 01 = 50%, 10 = 75%, 11 = 100%.

Parameters:
- TEMP_W, 8, temperature sample width (unsigned).
- T_ON, 40, rising threshold OFF -> 25%.
- T_50, 50, rising threshold 25% -> 50%.
- T_75, 60, rising threshold 50% -> 75%.
- T_100, 70, rising threshold 75% -> 100%.
- HYST, 3, falling hysteresis. A level is left downward only when temp < (its threshold - HYST).
- DWELL_CYC, 1024, minimum clk cycles between consecutive level changes (>= 1).
- KICK_CYC, 4096, spin-up duration at 100% on fan start (>= 1).
- Legal only if T_ON < T_50 < T_75 < T_100. Any HYST is legal; (threshold - HYST) saturates at 0.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- temp_valid  in  1  single-cycle strobe qualifying temp.
- temp  in  TEMP_W  unsigned temperature sample.
- force_max  in  1  level-sensitive override to 100%.
- fan_switch  out  1  fan enable to driver.
- speed_choice  out  2  speed code to driver pwm_choice/power_choice.
- kick_active  out  1  high while in the KICK state.

Behaviour:
- Reset (async, rst_n=0):
  - state=OFF, level=L25, temp_q=0, dwell_cnt=0, kick_cnt=0.
  - Outputs: fan_switch=0, speed_choice=00, kick_active=0.
  - Reset mid-operation aborts any kick or dwell immediately.
- Sample latch: temp_q <= temp on each clk edge where temp_valid=1. All decisions use temp_q, never temp directly.
- Threshold counts (compare at TEMP_W+1 bits, unsigned):
  - up_cnt = number of {T_ON, T_50, T_75, T_100} that are <= temp_q (range 0..4).
  - dn_cnt = number of saturated (T - HYST) values that are <= temp_q (range 0..4).
  - dn_cnt >= up_cnt always holds.
- Current index cur: OFF=0, L25=1, L50=2, L75=3, L100=4.
- Dwell counter:
  - Loaded with DWELL_CYC-1 on every state/level change.
  - Otherwise decrements each cycle and saturates at 0.
  - dwell_ok = (dwell_cnt == 0).
- FSM states: OFF, KICK, RUN.
  - OFF -> KICK when up_cnt >= 1 and dwell_ok. Load kick_cnt = KICK_CYC-1.
  - KICK: kick_cnt decrements each cycle. At the edge where kick_cnt == 0, go to RUN with level=L25 and reload dwell_cnt. KICK lasts exactly KICK_CYC cycles.
  - KICK ignores temperature and dwell; a falling temperature during the kick does not abort it.
  - RUN, when dwell_ok:
    - If up_cnt > cur, level steps up by exactly one.
    - Else if dn_cnt < cur, step down by exactly one; stepping down from L25 goes to OFF.
    - Otherwise hold.
    - Never more than one step per change.
- Output decode is combinational from registered state and level only (glitch-free):
  - OFF: fan_switch=0, speed_choice=00.
  - KICK: fan_switch=1, speed_choice=11, kick_active=1.
  - RUN: fan_switch=1, speed_choice = level-1 (L25=00 ... L100=11).
- force_max=1: outputs are fan_switch=1, speed_choice=11, with kick_active unaffected. The internal FSM, dwell and kick counters keep running unchanged. On release, outputs revert to the FSM decode in the same cycle.
- Latency:
  - temp_valid sampled at edge k means the decision uses the new temp_q at edge k+1.
  - Outputs change after edge k+1, provided the dwell has expired.
- Simultaneous temp_valid and dwell expiry: the decision at that edge uses the old temp_q.
- Counter widths: $clog2 of DWELL_CYC and of KICK_CYC (minimum 1 bit). No wrap is possible because both counters saturate or reload.

Test Plan:
Parameters for the bench: DWELL_CYC=4, KICK_CYC=8, HYST=3, other defaults.
- Reset, then temp=20 strobed: fan_switch=0 and speed_choice=00 indefinitely. Assert rst_n=0 asynchronously between edges: outputs are 0 immediately.
- temp=45 strobed at edge k: fan_switch=1, speed_choice=11, kick_active=1 from edge k+1 for exactly 8 cycles. Then speed_choice=00 (L25) and kick_active=0.
- From steady L25, strobe temp=75: speed_choice steps 01, 10, 11 at edges spaced exactly 4 cycles apart.
- Hysteresis from L100: temp=68 holds 11; temp=66 steps to 10 after dwell; temp=57 holds 10; temp=56 steps to 01.
- From L25, temp=36 leads to OFF (fan_switch=0). A subsequent temp=40 within the dwell waits for dwell expiry, then the kick repeats.
- force_max pulsed 3 cycles while at L50: outputs are 1/11 during the pulse and revert to 01 on the first cycle after release. Dwell timing is unchanged.

Source files
------------

// File: rtl/fan_speed_governor.sv
// Temperature-driven fan speed selector with hysteresis, step dwell and a full-speed
// spin-up kick. Feeds the fan driver's enable and shared pwm/power speed code.
module fan_speed_governor #(
  parameter int unsigned TEMP_W    = 8,
  parameter int unsigned T_ON      = 40,
  parameter int unsigned T_50      = 50,
  parameter int unsigned T_75      = 60,
  parameter int unsigned T_100     = 70,
  parameter int unsigned HYST      = 3,
  parameter int unsigned DWELL_CYC = 1024,
  parameter int unsigned KICK_CYC  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp,
  input  logic              force_max,
  output logic              fan_switch,
  output logic [1:0]        speed_choice,
  output logic              kick_active
);

  localparam int unsigned CW = TEMP_W + 1;
  localparam int unsigned DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int unsigned KW = (KICK_CYC > 1) ? $clog2(KICK_CYC) : 1;

  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYC - 1);
  localparam logic [KW-1:0] KICK_LOAD  = KW'(KICK_CYC - 1);

  localparam logic [CW-1:0] UP_ON  = CW'(T_ON);
  localparam logic [CW-1:0] UP_50  = CW'(T_50);
  localparam logic [CW-1:0] UP_75  = CW'(T_75);
  localparam logic [CW-1:0] UP_100 = CW'(T_100);

  // Falling thresholds saturate at zero for large hysteresis.
  localparam logic [CW-1:0] DN_ON  = (T_ON  > HYST) ? CW'(T_ON  - HYST) : '0;
  localparam logic [CW-1:0] DN_50  = (T_50  > HYST) ? CW'(T_50  - HYST) : '0;
  localparam logic [CW-1:0] DN_75  = (T_75  > HYST) ? CW'(T_75  - HYST) : '0;
  localparam logic [CW-1:0] DN_100 = (T_100 > HYST) ? CW'(T_100 - HYST) : '0;

  localparam logic [1:0] LVL_25  = 2'b00;
  localparam logic [1:0] LVL_100 = 2'b11;

  typedef enum logic [1:0] {StOff, StKick, StRun} state_e;

  state_e            state_q;
  logic [1:0]        level_q;
  logic [TEMP_W-1:0] temp_q;
  logic [DW-1:0]     dwell_q;
  logic [KW-1:0]     kick_cnt_q;

  logic [CW-1:0] temp_ext;
  logic [2:0]    up_cnt;
  logic [2:0]    dn_cnt;
  logic [2:0]    cur;
  logic          dwell_ok;
  logic [DW-1:0] dwell_dec;

  assign temp_ext  = {1'b0, temp_q};
  assign dwell_ok  = (dwell_q == '0);
  assign dwell_dec = dwell_ok ? '0 : dwell_q - DW'(1);
  // Level code equals speed code, so the running index is level + 1.
  assign cur       = (state_q == StRun) ? ({1'b0, level_q} + 3'd1) : 3'd0;

  always_comb begin
    up_cnt = '0;
    dn_cnt = '0;
    if (temp_ext >= UP_ON)  up_cnt = up_cnt + 3'd1;
    if (temp_ext >= UP_50)  up_cnt = up_cnt + 3'd1;
    if (temp_ext >= UP_75)  up_cnt = up_cnt + 3'd1;
    if (temp_ext >= UP_100) up_cnt = up_cnt + 3'd1;
    if (temp_ext >= DN_ON)  dn_cnt = dn_cnt + 3'd1;
    if (temp_ext >= DN_50)  dn_cnt = dn_cnt + 3'd1;
    if (temp_ext >= DN_75)  dn_cnt = dn_cnt + 3'd1;
    if (temp_ext >= DN_100) dn_cnt = dn_cnt + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StOff;
      level_q    <= LVL_25;
      temp_q     <= '0;
      dwell_q    <= '0;
      kick_cnt_q <= '0;
    end else begin
      if (temp_valid) temp_q <= temp;
      unique case (state_q)
        StOff: begin
          if (dwell_ok && (up_cnt != 3'd0)) begin
            state_q    <= StKick;
            kick_cnt_q <= KICK_LOAD;
            dwell_q    <= DWELL_LOAD;
          end else begin
            dwell_q <= dwell_dec;
          end
        end
        StKick: begin
          // Temperature and dwell are ignored until the kick completes.
          if (kick_cnt_q == '0) begin
            state_q <= StRun;
            level_q <= LVL_25;
            dwell_q <= DWELL_LOAD;
          end else begin
            kick_cnt_q <= kick_cnt_q - KW'(1);
            dwell_q    <= dwell_dec;
          end
        end
        StRun: begin
          if (dwell_ok && (up_cnt > cur) && (level_q != LVL_100)) begin
            level_q <= level_q + 2'd1;
            dwell_q <= DWELL_LOAD;
          end else if (dwell_ok && (dn_cnt < cur)) begin
            if (level_q == LVL_25) state_q <= StOff;
            else                   level_q <= level_q - 2'd1;
            dwell_q <= DWELL_LOAD;
          end else begin
            dwell_q <= dwell_dec;
          end
        end
        default: begin
          state_q <= StOff;
          dwell_q <= DWELL_LOAD;
        end
      endcase
    end
  end

  // Decode from registered state only; force_max overrides speed, not kick_active.
  always_comb begin
    fan_switch   = 1'b0;
    speed_choice = 2'b00;
    kick_active  = 1'b0;
    unique case (state_q)
      StKick: begin
        fan_switch   = 1'b1;
        speed_choice = 2'b11;
        kick_active  = 1'b1;
      end
      StRun: begin
        fan_switch   = 1'b1;
        speed_choice = level_q;
      end
      default: ;
    endcase
    if (force_max) begin
      fan_switch   = 1'b1;
      speed_choice = 2'b11;
    end
  end

endmodule

// File: tb/tb_fan_speed_governor.sv
// Scoreboard bench for fan_speed_governor: expected {fan_switch, speed_choice, kick_active}
// words are queued as stimulus is driven and compared once per cycle on the falling edge.
`timescale 1ns/1ps
module tb_fan_speed_governor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       temp_valid = 1'b0;
  logic [7:0] temp = 8'd0;
  logic       force_max = 1'b0;
  logic       fan_switch;
  logic [1:0] speed_choice;
  logic       kick_active;

  typedef logic [3:0] exp_t;  // {fan_switch, speed_choice, kick_active}
  localparam exp_t E_OFF   = 4'b0000;
  localparam exp_t E_KICK  = 4'b1111;
  localparam exp_t E_L25   = 4'b1000;
  localparam exp_t E_L50   = 4'b1010;
  localparam exp_t E_L75   = 4'b1100;
  localparam exp_t E_L100  = 4'b1110;
  localparam exp_t E_FORCE = 4'b1110;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  fan_speed_governor #(
    .TEMP_W   (8),
    .T_ON     (40),
    .T_50     (50),
    .T_75     (60),
    .T_100    (70),
    .HYST     (3),
    .DWELL_CYC(4),
    .KICK_CYC (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .temp_valid  (temp_valid),
    .temp        (temp),
    .force_max   (force_max),
    .fan_switch  (fan_switch),
    .speed_choice(speed_choice),
    .kick_active (kick_active)
  );

  always #5 clk = ~clk;

  task automatic push(input exp_t e, input int n);
    repeat (n) sb.push_back(e);
  endtask

  // Drive a one-cycle strobe; returns 1ns after the sampling edge.
  task automatic strobe(input logic [7:0] t);
    temp       = t;
    temp_valid = 1'b1;
    @(posedge clk);
    #1;
    temp_valid = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    exp_t got;
    int   n = 0;
    #1 rst_n = 1'b0;
    #2;
    total++;
    got = {fan_switch, speed_choice, kick_active};
    if (got !== E_OFF) begin
      bad++;
      $display("FAIL reset_hold got=%b exp=%b", got, E_OFF);
    end
    @(negedge clk);
    rst_n = 1'b1;
    strobe(8'd20);
    push(E_OFF, 12);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      got = {fan_switch, speed_choice, kick_active};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset_cold cyc=%0d got=%b exp=%b", n, got, e);
      end
      n++;
    end
  endtask

  task automatic test_kick();
    exp_t e;
    exp_t got;
    int   n = 0;
    strobe(8'd45);
    push(E_OFF, 1);
    push(E_KICK, 8);
    push(E_L25, 6);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      got = {fan_switch, speed_choice, kick_active};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL kick cyc=%0d got=%b exp=%b", n, got, e);
      end
      n++;
    end
  endtask

  task automatic test_step_up();
    exp_t e;
    exp_t got;
    int   n = 0;
    strobe(8'd75);
    push(E_L25, 1);
    push(E_L50, 4);
    push(E_L75, 4);
    push(E_L100, 6);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      got = {fan_switch, speed_choice, kick_active};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL step_up cyc=%0d got=%b exp=%b", n, got, e);
      end
      n++;
    end
  endtask

  task automatic test_hysteresis();
    exp_t       e;
    exp_t       got;
    logic [7:0] temps[4] = '{8'd68, 8'd66, 8'd57, 8'd56};
    int         n = 0;
    for (int i = 0; i < 4; i++) begin
      strobe(temps[i]);
      unique case (i)
        0: push(E_L100, 6);
        1: begin push(E_L100, 1); push(E_L75, 6); end
        2: push(E_L75, 6);
        default: begin push(E_L75, 1); push(E_L50, 6); end
      endcase
      while (sb.size() > 0) begin
        @(negedge clk);
        e = sb.pop_front();
        got = {fan_switch, speed_choice, kick_active};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL hyst t=%0d cyc=%0d got=%b exp=%b", temps[i], n, got, e);
        end
        n++;
      end
    end
  endtask

  task automatic test_off_rekick();
    exp_t e;
    exp_t got;
    int   n = 0;
    strobe(8'd36);
    push(E_L50, 1);
    push(E_L25, 4);
    push(E_OFF, 1);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      got = {fan_switch, speed_choice, kick_active};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL off_step cyc=%0d got=%b exp=%b", n, got, e);
      end
      n++;
    end
    // Re-arm inside the OFF dwell: the kick must wait for dwell expiry.
    strobe(8'd40);
    push(E_OFF, 3);
    push(E_KICK, 8);
    push(E_L25, 4);
    n = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      got = {fan_switch, speed_choice, kick_active};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL rekick cyc=%0d got=%b exp=%b", n, got, e);
      end
      n++;
    end
  endtask

  task automatic test_force();
    exp_t e;
    exp_t got;
    strobe(8'd55);
    push(E_L25, 1);
    push(E_FORCE, 3);
    push(E_L50, 1);
    push(E_L75, 4);
    // Force starts right after the step to L50 while 65 is strobed; the L75 step
    // must still land exactly one dwell after the L50 step.
    for (int j = 0; j < 9; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
        if (j == 1) begin
          force_max  = 1'b1;
          temp       = 8'd65;
          temp_valid = 1'b1;
        end
        if (j == 2) temp_valid = 1'b0;
        if (j == 4) force_max = 1'b0;
      end
      @(negedge clk);
      e = sb.pop_front();
      got = {fan_switch, speed_choice, kick_active};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL force cyc=%0d got=%b exp=%b", j, got, e);
      end
    end
  endtask

  task automatic test_kick_hold();
    exp_t e;
    exp_t got;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    got = {fan_switch, speed_choice, kick_active};
    if (got !== E_OFF) begin
      bad++;
      $display("FAIL async_rst_run got=%b exp=%b", got, E_OFF);
    end
    @(negedge clk);
    rst_n = 1'b1;
    strobe(8'd45);
    push(E_OFF, 1);
    push(E_KICK, 8);
    push(E_L25, 4);
    push(E_OFF, 3);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      e = sb.pop_front();
      got = {fan_switch, speed_choice, kick_active};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL kick_hold cyc=%0d got=%b exp=%b", j, got, e);
      end
      // Cold sample mid-kick must not abort it.
      if (j == 2) begin
        temp       = 8'd20;
        temp_valid = 1'b1;
      end
      if (j == 3) temp_valid = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    exp_t got;
    int   n = 0;
    logic seen = 1'b0;
    strobe(8'd45);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = kick_active;
    end
    total++;
    if (seen !== 1'b1) begin
      bad++;
      $display("FAIL async_kick_start got=%b exp=1", seen);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    got = {fan_switch, speed_choice, kick_active};
    if (got !== E_OFF) begin
      bad++;
      $display("FAIL async_rst_kick got=%b exp=%b", got, E_OFF);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // temp_q was cleared, so the fan must stay off.
    push(E_OFF, 6);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      got = {fan_switch, speed_choice, kick_active};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL post_rst cyc=%0d got=%b exp=%b", n, got, e);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_kick();
    test_step_up();
    test_hysteresis();
    test_off_rekick();
    test_force();
    test_kick_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
